// File: rtl/loader_pkg.sv
// Shared definitions for the boot loader: frame constants, field widths and
// the loader state encoding.
package loader_pkg;

  localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
  localparam int         ADDR_W_DEFAULT = 8;
  localparam int         HDR_W          = 8;
  localparam int         LEN_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/boot_loader.sv
// Receives a framed program image (MAGIC, length, payload, checksum) and writes
// it into RAM from address 0, holding the CPU in reset until the checksum is good.
module boot_loader
  import loader_pkg::*;
#(
  parameter logic [HDR_W-1:0] MAGIC  = MAGIC_DEFAULT,
  parameter int               ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so a length field of 0 can represent a full 2^ADDR_W image.
  localparam int CNT_W = ADDR_W + 1;

  loader_state_t     state;
  loader_state_t     state_next;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] load_index;
  logic [7:0]        checksum;
  logic              xfer;

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (xfer && (in_data == MAGIC)) state_next = ST_LEN;
      end
      ST_LEN: begin
        if (xfer) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (xfer && (remaining == CNT_W'(1))) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (xfer) state_next = (in_data == checksum) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        if (start) state_next = ST_IDLE;
      end
      ST_ERR: begin
        if (start) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs decode straight from the state register, never from in_*.
  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      ST_IDLE:  in_ready = 1'b1;
      ST_LEN:   begin in_ready = 1'b1; busy = 1'b1; end
      ST_LOAD:  begin in_ready = 1'b1; busy = 1'b1; end
      ST_CHECK: begin in_ready = 1'b1; busy = 1'b1; end
      ST_DONE:  begin cpu_hold = 1'b0; done = 1'b1; end
      ST_ERR:   error = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  // Payload datapath: each accepted byte becomes a one-cycle RAM write on the
  // following cycle; the index wraps naturally on a full-size image.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      remaining  <= '0;
      load_index <= '0;
      checksum   <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        ST_LEN: begin
          if (xfer) begin
            remaining  <= (in_data == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(in_data);
            load_index <= '0;
            checksum   <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            ram_we     <= 1'b1;
            ram_addr   <= load_index;
            ram_data   <= in_data;
            checksum   <= checksum + in_data;
            load_index <= load_index + 1'b1;
            remaining  <= remaining - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
